// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter
//   Writeback stage that owns the single write port of the 32x32 register
//   file. It merges single-cycle ALU results with long-latency results
//   (load unit, later mul/div) into one registered write per cycle.
//   Long-latency results queue in a small in-order FIFO.
//   A starvation counter guarantees the FIFO drains even under a continuous
//   ALU stream. A pending scoreboard tells the hazard unit which registers
//   still wait for a long-latency result.
//
//   Optional feature: define WB_BYPASS_EN to add two combinational bypass
//   read ports. They cover the window between the registered write
//   (posedge) and the register file update (following negedge).
//   With WB_BYPASS_EN undefined, those ports and their logic are absent.

module rf_writeback_arbiter #(
   parameter int DEPTH        = 4,   // long-latency FIFO entries, power of 2, >= 2
   parameter int STARVE_LIMIT = 3    // ALU grants over a non-empty FIFO before it is forced
) (
   input  logic        clk,
   input  logic        reset,
   // single-cycle ALU results
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   // long-latency results
   input  logic        lsu_valid,
   output logic        lsu_ready,
   input  logic [4:0]  lsu_rd,
   input  logic [31:0] lsu_data,
   // issue-side marking of long-latency destinations
   input  logic        mark_valid,
   input  logic [4:0]  mark_rd,
   output logic [31:0] pending,
   // register-file write port
   output logic        write_en,
   output logic [4:0]  dst_addr,
   output logic [31:0] dst_data
`ifdef WB_BYPASS_EN
   ,
   input  logic [4:0]  byp_addr1,
   input  logic [4:0]  byp_addr2,
   output logic        byp_hit1,
   output logic        byp_hit2,
   output logic [31:0] byp_data1,
   output logic [31:0] byp_data2
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   // ------------------------------------------------------------------
   // FIFO storage: each word is {rd, data}. Storage has no reset so it
   // can map onto distributed/block RAM. The head is only ever consumed
   // into the registered write port, so the read is effectively
   // registered.
   // ------------------------------------------------------------------
   logic [36:0]   fifo_mem [DEPTH];
   logic [AW:0]   wr_ptr_reg, wr_ptr_next;
   logic [AW:0]   rd_ptr_reg, rd_ptr_next;
   logic [36:0]   head_word;
   logic [4:0]    head_rd;
   logic [31:0]   head_data;

   logic          fifo_empty;
   logic          fifo_full;
   logic          fifo_push;
   logic          fifo_pop;

   // arbitration state
   logic [SW-1:0] starve_reg, starve_next;
   logic          force_fifo;
   logic          alu_grant;

   // registered write port
   logic          write_en_reg, write_en_next;
   logic [4:0]    dst_addr_reg, dst_addr_next;
   logic [31:0]   dst_data_reg, dst_data_next;

   // pending scoreboard (bit 0 does not exist: x0 is never pending)
   logic [31:1]   pending_reg, pending_next;
   logic [31:1]   pend_set;
   logic [31:1]   pend_clr;

   // ------------------------------------------------------------------
   // FIFO status. Pointers carry one extra wrap bit so full and empty are
   // distinguishable without a separate counter.
   // ------------------------------------------------------------------
   assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
   assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

   assign head_word  = fifo_mem[rd_ptr_reg[AW-1:0]];
   assign head_rd    = head_word[36:32];
   assign head_data  = head_word[31:0];

   // ------------------------------------------------------------------
   // Arbitration. A saturated starve counter with a non-empty FIFO forces
   // the FIFO head through and back-pressures the ALU for that cycle.
   // Otherwise the ALU wins whenever it presents a result, and the FIFO
   // drains in ALU idle cycles.
   // ------------------------------------------------------------------
   assign force_fifo = (starve_reg == STARVE_MAX) && !fifo_empty;

   assign alu_ready  = !reset && !force_fifo;
   assign alu_grant  = alu_valid && alu_ready;

   // No pass-through when full: a pop in the same cycle does not open a slot.
   assign lsu_ready  = !reset && !fifo_full;
   assign fifo_push  = lsu_valid && lsu_ready;

   assign fifo_pop   = !reset && !fifo_empty && (force_fifo || !alu_valid);

   // Pointer advance for push and pop
   always_comb begin
      wr_ptr_next = wr_ptr_reg + (AW+1)'(fifo_push);
      rd_ptr_next = rd_ptr_reg + (AW+1)'(fifo_pop);
   end

   // Starve counter: counts ALU wins over waiting FIFO data, clears on pop or empty
   always_comb begin
      starve_next = starve_reg;
      if (fifo_pop || fifo_empty) begin
         starve_next = '0;
      end else if (alu_grant && (starve_reg != STARVE_MAX)) begin
         starve_next = starve_reg + 1'b1;
      end
   end

   // Next write-port value: the granted source lands here; rd==0 updates addr/data but never writes
   always_comb begin
      write_en_next = 1'b0;
      dst_addr_next = dst_addr_reg;
      dst_data_next = dst_data_reg;
      if (fifo_pop) begin
         write_en_next = (head_rd != 5'd0);
         dst_addr_next = head_rd;
         dst_data_next = head_data;
      end else if (alu_grant) begin
         write_en_next = (alu_rd != 5'd0);
         dst_addr_next = alu_rd;
         dst_data_next = alu_data;
      end
   end

   // ------------------------------------------------------------------
   // Scoreboard. Each register decodes its own set (issue mark) and clear
   // (FIFO pop of that destination). Set is applied after clear so a
   // re-issue in the same cycle as the old result's retirement stays
   // pending. ALU writes never touch the scoreboard.
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 1; gi < 32; gi++) begin : g_sb
         assign pend_set[gi] = mark_valid && (mark_rd == 5'(gi));
         assign pend_clr[gi] = fifo_pop && (head_rd == 5'(gi));
      end
   endgenerate

   // Scoreboard next state: clear first, then set, so set wins
   always_comb begin
      pending_next = (pending_reg & ~pend_clr) | pend_set;
   end

   // FIFO storage write; no reset so the array stays RAM-mappable
   always_ff @(posedge clk) begin
      if (fifo_push) begin
         fifo_mem[wr_ptr_reg[AW-1:0]] <= {lsu_rd, lsu_data};
      end
   end

   // State registers; reset drops any transfer in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         starve_reg   <= '0;
         write_en_reg <= 1'b0;
         dst_addr_reg <= 5'd0;
         dst_data_reg <= 32'd0;
         pending_reg  <= '0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         starve_reg   <= starve_next;
         write_en_reg <= write_en_next;
         dst_addr_reg <= dst_addr_next;
         dst_data_reg <= dst_data_next;
         pending_reg  <= pending_next;
      end
   end

   assign write_en = write_en_reg;
   assign dst_addr = dst_addr_reg;
   assign dst_data = dst_data_reg;
   assign pending  = {pending_reg, 1'b0};

`ifdef WB_BYPASS_EN
   // ------------------------------------------------------------------
   // Bypass: between the registered write and the register file's negedge
   // update, readers of dst_addr must see dst_data instead of the stale
   // file content.
   // ------------------------------------------------------------------
   assign byp_hit1  = write_en_reg && (dst_addr_reg == byp_addr1) && (byp_addr1 != 5'd0);
   assign byp_hit2  = write_en_reg && (dst_addr_reg == byp_addr2) && (byp_addr2 != 5'd0);
   assign byp_data1 = dst_data_reg;
   assign byp_data2 = dst_data_reg;
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Testbench for rf_writeback_arbiter.
//   Inputs change on the negedge. Every cycle, 2 time units later, the DUT
//   outputs are compared against a queue-based behavioural model, which
//   then advances with the current inputs. Directed sequences add literal
//   expectations. A randomized phase follows. Bypass checks are compiled
//   in when WB_BYPASS_EN is defined.

module tb_rf_writeback_arbiter;

   localparam int DEPTH        = 4;
   localparam int STARVE_LIMIT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid, alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid, lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        mark_valid;
   logic [4:0]  mark_rd;
   logic [31:0] pending;
   logic        write_en;
   logic [4:0]  dst_addr;
   logic [31:0] dst_data;
`ifdef WB_BYPASS_EN
   logic [4:0]  byp_addr1, byp_addr2;
   logic        byp_hit1, byp_hit2;
   logic [31:0] byp_data1, byp_data2;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   rf_writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk        (clk),
      .reset      (reset),
      .alu_valid  (alu_valid),
      .alu_ready  (alu_ready),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .lsu_valid  (lsu_valid),
      .lsu_ready  (lsu_ready),
      .lsu_rd     (lsu_rd),
      .lsu_data   (lsu_data),
      .mark_valid (mark_valid),
      .mark_rd    (mark_rd),
      .pending    (pending),
      .write_en   (write_en),
      .dst_addr   (dst_addr),
      .dst_data   (dst_data)
`ifdef WB_BYPASS_EN
      ,
      .byp_addr1  (byp_addr1),
      .byp_addr2  (byp_addr2),
      .byp_hit1   (byp_hit1),
      .byp_hit2   (byp_hit2),
      .byp_data1  (byp_data1),
      .byp_data2  (byp_data2)
`endif
   );

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   wb_t         fq[$];      // long-latency results waiting, oldest first
   logic        m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   logic [31:0] m_pend;
   int          m_starve;   // ALU wins while results wait

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      fq.delete();
      m_we     = 1'b0;
      m_addr   = 5'd0;
      m_data   = 32'd0;
      m_pend   = 32'd0;
      m_starve = 0;
   endtask

   // Compare DUT against the model, then advance the model by one clock
   task automatic model_cycle();
      wb_t  e;
      logic emp, frc, do_pop, do_alu, do_push;
      logic exp_lsu_ready, exp_alu_ready;
      emp           = (fq.size() == 0);
      frc           = (m_starve == STARVE_LIMIT) && !emp;
      exp_lsu_ready = !reset && (fq.size() < DEPTH);
      exp_alu_ready = !reset && !frc;

      chk("write_en",  32'(write_en),  32'(m_we));
      chk("dst_addr",  32'(dst_addr),  32'(m_addr));
      chk("dst_data",  dst_data,       m_data);
      chk("pending",   pending,        m_pend);
      chk("alu_ready", 32'(alu_ready), 32'(exp_alu_ready));
      chk("lsu_ready", 32'(lsu_ready), 32'(exp_lsu_ready));
`ifdef WB_BYPASS_EN
      chk("byp_hit1",  32'(byp_hit1), 32'(m_we && (m_addr == byp_addr1) && (byp_addr1 != 0)));
      chk("byp_hit2",  32'(byp_hit2), 32'(m_we && (m_addr == byp_addr2) && (byp_addr2 != 0)));
      chk("byp_data1", byp_data1, m_data);
      chk("byp_data2", byp_data2, m_data);
`endif
      if (m_we)
         $display("[TB] t=%0t write x%0d = %08h", $time, m_addr, m_data);

      if (reset) begin
         model_reset();
      end else begin
         do_pop  = frc || (!alu_valid && !emp);
         do_alu  = !frc && alu_valid;
         do_push = lsu_valid && (fq.size() < DEPTH);
         if (do_pop) begin
            e      = fq.pop_front();
            m_we   = (e.rd != 0);
            m_addr = e.rd;
            m_data = e.data;
            if (e.rd != 0) m_pend[e.rd] = 1'b0;
         end else if (do_alu) begin
            m_we   = (alu_rd != 0);
            m_addr = alu_rd;
            m_data = alu_data;
         end else begin
            m_we   = 1'b0;
         end
         if (mark_valid && mark_rd != 0) m_pend[mark_rd] = 1'b1;
         if (do_push) fq.push_back({lsu_rd, lsu_data});
         if (do_pop || emp)
            m_starve = 0;
         else if (do_alu && m_starve < STARVE_LIMIT)
            m_starve++;
      end
   endtask

   // Called at a negedge with inputs set: check, advance model, wait next negedge
   task automatic step();
      #2;
      model_cycle();
      @(negedge clk);
   endtask

   task automatic idle();
      alu_valid  = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
      lsu_valid  = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
      mark_valid = 1'b0; mark_rd = 5'd0;
`ifdef WB_BYPASS_EN
      byp_addr1  = 5'd0; byp_addr2 = 5'd0;
`endif
   endtask

   initial begin
      reset = 1'b1;
      idle();
      model_reset();
      @(negedge clk);
      step();
      step();

      // ---- reset state ----
      reset = 1'b0;
      #1;
      chk("rst_write_en",  32'(write_en),  32'd0);
      chk("rst_dst_addr",  32'(dst_addr),  32'd0);
      chk("rst_pending",   pending,        32'd0);
      chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);
      chk("rst_alu_ready", 32'(alu_ready), 32'd1);
      step();

      // ---- ALU only ----
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      step();
      alu_rd = 5'd0; alu_data = 32'h0000_1234;
      #1;
      chk("alu_we",   32'(write_en), 32'd1);
      chk("alu_addr", 32'(dst_addr), 32'd5);
      chk("alu_data", dst_data,      32'hDEADBEEF);
      step();
      alu_valid = 1'b0;
      #1;
      chk("alu_x0_we",   32'(write_en), 32'd0);
      chk("alu_x0_addr", 32'(dst_addr), 32'd0);
      chk("alu_x0_data", dst_data,      32'h0000_1234);
      step();

      // ---- priority / starvation ----
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h0000_0100;
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0000_7777;
      step();
      lsu_valid = 1'b0;
      step(); step(); step();
      #1;
      chk("starve_alu_ready", 32'(alu_ready), 32'd0);
      step();
      #1;
      chk("starve_x7_we",   32'(write_en), 32'd1);
      chk("starve_x7_addr", 32'(dst_addr), 32'd7);
      chk("starve_x7_data", dst_data,      32'h0000_7777);
      chk("starve_resume",  32'(alu_ready), 32'd1);
      step();
      #1;
      chk("starve_alu_back", 32'(dst_addr), 32'd1);

      // ---- full FIFO ----
      alu_rd = 5'd2; alu_data = 32'h0000_0200;
      for (int k = 0; k < 4; k++) begin
         lsu_valid = 1'b1; lsu_rd = 5'(10 + k); lsu_data = 32'(32'hA0 + k);
         step();
      end
      lsu_valid = 1'b1; lsu_rd = 5'd14; lsu_data = 32'hA4;
      #1;
      chk("full_lsu_ready", 32'(lsu_ready), 32'd0);
      step();
      #1;
      chk("full_first_pop", 32'(dst_addr), 32'd10);
      chk("full_reopen",    32'(lsu_ready), 32'd1);
      step();
      idle();
      for (int k = 0; k < 4; k++) begin
         step();
         #1;
         chk("full_order", 32'(dst_addr), 32'(11 + k));
      end
      step();

      // ---- scoreboard ----
      mark_valid = 1'b1; mark_rd = 5'd9;
      step();
      mark_valid = 1'b0;
      #1;
      chk("sb_mark9", 32'(pending[9]), 32'd1);
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
      step();
      lsu_valid = 1'b0;
      step();
      #1;
      chk("sb_pop9", 32'(pending[9]), 32'd0);
      lsu_valid = 1'b1;
      step();
      lsu_valid = 1'b0; mark_valid = 1'b1; mark_rd = 5'd9;
      step();
      #1;
      chk("sb_set_wins", 32'(pending[9]), 32'd1);
      mark_rd = 5'd0;
      step();
      mark_valid = 1'b0;
      #1;
      chk("sb_mark_x0", pending, 32'h0000_0200);
      step();

      // ---- reset mid-stream ----
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
      lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'h20;
      mark_valid = 1'b1; mark_rd = 5'd22;
      step();
      mark_valid = 1'b0; lsu_rd = 5'd21; lsu_data = 32'h21;
      step();
      reset = 1'b1;
      #1;
      chk("rst_mid_alu_ready", 32'(alu_ready), 32'd0);
      chk("rst_mid_lsu_ready", 32'(lsu_ready), 32'd0);
      step();
      reset = 1'b0;
      idle();
      #1;
      chk("rst_mid_we",        32'(write_en),  32'd0);
      chk("rst_mid_pending",   pending,        32'd0);
      chk("rst_mid_lsu_ready", 32'(lsu_ready), 32'd1);
      step();
      step();

`ifdef WB_BYPASS_EN
      // ---- bypass ----
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h12;
      step();
      alu_valid = 1'b0;
      byp_addr1 = 5'd3;
      #1;
      chk("byp_hit_x3",  32'(byp_hit1), 32'd1);
      chk("byp_data_x3", byp_data1,     32'h12);
      byp_addr1 = 5'd0;
      #1;
      chk("byp_hit_x0",  32'(byp_hit1), 32'd0);
      step();
`endif

      // ---- randomized phase ----
      for (int n = 0; n < 3000; n++) begin
         reset      = ($urandom_range(0, 255) == 0);
         alu_valid  = $urandom_range(0, 1) == 1;
         alu_rd     = 5'($urandom_range(0, 7));
         alu_data   = $urandom;
         lsu_valid  = $urandom_range(0, 1) == 1;
         lsu_rd     = 5'($urandom_range(0, 7));
         lsu_data   = $urandom;
         mark_valid = $urandom_range(0, 3) == 0;
         mark_rd    = 5'($urandom_range(0, 7));
`ifdef WB_BYPASS_EN
         byp_addr1  = 5'($urandom_range(0, 7));
         byp_addr2  = 5'($urandom_range(0, 7));
`endif
         step();
      end
      reset = 1'b0;
      idle();
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
